// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings, data-phase select indices and default-slave
// state encoding for the slave response multiplexer.
package ahblite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int NUM_PORTS = 4;

  // Bit positions inside the one-hot data-phase select register
  localparam int SEL_W    = 6;
  localparam int SEL_P0   = 0;
  localparam int SEL_P1   = 1;
  localparam int SEL_P2   = 2;
  localparam int SEL_P3   = 3;
  localparam int SEL_DEF  = 4;
  localparam int SEL_NONE = 5;

  localparam logic [SEL_W-1:0] SEL_P0_OH   = 6'b000001;
  localparam logic [SEL_W-1:0] SEL_P1_OH   = 6'b000010;
  localparam logic [SEL_W-1:0] SEL_P2_OH   = 6'b000100;
  localparam logic [SEL_W-1:0] SEL_P3_OH   = 6'b001000;
  localparam logic [SEL_W-1:0] SEL_DEF_OH  = 6'b010000;
  localparam logic [SEL_W-1:0] SEL_NONE_OH = 6'b100000;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

  // Next one-hot data-phase select; lowest-numbered claiming port wins
  function automatic logic [SEL_W-1:0] next_sel(input logic [NUM_PORTS-1:0] act,
                                                input logic def_act);
    logic [SEL_W-1:0] sel;
    sel = SEL_NONE_OH;
    if (act[0]) begin
      sel = SEL_P0_OH;
    end else if (act[1]) begin
      sel = SEL_P1_OH;
    end else if (act[2]) begin
      sel = SEL_P2_OH;
    end else if (act[3]) begin
      sel = SEL_P3_OH;
    end else if (def_act) begin
      sel = SEL_DEF_OH;
    end else begin
      sel = SEL_NONE_OH;
    end
    return sel;
  endfunction

endpackage

// File: rtl/ahblite_default_slave.sv
// Default slave: answers every unclaimed active transfer with the two-cycle
// AHB ERROR response (HREADY low then high, HRESP high in both cycles).
module ahblite_default_slave
  import ahblite_pkg::*;
(
  input  logic HCLK,
  input  logic HRESET,
  input  logic sel_in,
  input  logic HREADY,
  output logic ds_hreadyout,
  output logic ds_hresp
);

  ds_state_e state_r;
  ds_state_e state_next_s;
  logic      hreadyout_r;
  logic      hresp_r;

  // Next-state logic; ERR1 always runs into ERR2 so a cancel cannot shorten it
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      DS_IDLE: begin
        if (HREADY && sel_in) begin
          state_next_s = DS_ERR1;
        end else begin
          state_next_s = DS_IDLE;
        end
      end
      DS_ERR1: state_next_s = DS_ERR2;
      DS_ERR2: begin
        if (HREADY && sel_in) begin
          state_next_s = DS_ERR1;
        end else begin
          state_next_s = DS_IDLE;
        end
      end
      default: state_next_s = DS_IDLE;
    endcase
  end

  // State register with outputs registered from the next state
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_r     <= DS_IDLE;
      hreadyout_r <= 1'b1;
      hresp_r     <= HRESP_OKAY;
    end else begin
      state_r     <= state_next_s;
      hreadyout_r <= (state_next_s != DS_ERR1);
      hresp_r     <= (state_next_s != DS_IDLE) ? HRESP_ERROR : HRESP_OKAY;
    end
  end

  assign ds_hreadyout = hreadyout_r;
  assign ds_hresp     = hresp_r;

endmodule

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite response multiplexer: registers the decoder's slave select in the
// address phase and returns that slave's ready/response/data in the data phase.
module ahblite_slave_mux
  import ahblite_pkg::*;
#(
  parameter logic Port0_en = 1'b0,
  parameter logic Port1_en = 1'b0,
  parameter logic Port2_en = 1'b0,
  parameter logic Port3_en = 1'b0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  HTRANS,
  input  logic        P0_HSEL,
  input  logic        P1_HSEL,
  input  logic        P2_HSEL,
  input  logic        P3_HSEL,
  input  logic        P0_HREADYOUT,
  input  logic        P1_HREADYOUT,
  input  logic        P2_HREADYOUT,
  input  logic        P3_HREADYOUT,
  input  logic        P0_HRESP,
  input  logic        P1_HRESP,
  input  logic        P2_HRESP,
  input  logic        P3_HRESP,
  input  logic [31:0] P0_HRDATA,
  input  logic [31:0] P1_HRDATA,
  input  logic [31:0] P2_HRDATA,
  input  logic [31:0] P3_HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  logic [NUM_PORTS-1:0] act_s;
  logic                 htrans_active_s;
  logic                 def_act_s;
  logic [SEL_W-1:0]     sel_q_r;
  logic                 ds_hreadyout_s;
  logic                 ds_hresp_s;
  logic                 hready_s;
  logic                 hresp_s;
  logic [31:0]          hrdata_s;

  // Absent ports never claim a transfer
  assign act_s = {P3_HSEL & Port3_en, P2_HSEL & Port2_en,
                  P1_HSEL & Port1_en, P0_HSEL & Port0_en};

  // NONSEQ/SEQ are real transfers; IDLE/BUSY need no slave response
  always_comb begin
    htrans_active_s = 1'b0;
    case (HTRANS)
      HTRANS_IDLE, HTRANS_BUSY:  htrans_active_s = 1'b0;
      HTRANS_NONSEQ, HTRANS_SEQ: htrans_active_s = 1'b1;
      default:                   htrans_active_s = 1'b0;
    endcase
  end

  assign def_act_s = ~(|act_s) & htrans_active_s;

  // Data-phase select; held during wait states so the phase is extended
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      sel_q_r <= SEL_NONE_OH;
    end else if (HREADY) begin
      sel_q_r <= next_sel(act_s, def_act_s);
    end else begin
      sel_q_r <= sel_q_r;
    end
  end

  ahblite_default_slave u_default_slave (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .sel_in       (def_act_s),
    .HREADY       (HREADY),
    .ds_hreadyout (ds_hreadyout_s),
    .ds_hresp     (ds_hresp_s)
  );

  // Response mux; an unknown or NONE select answers zero-wait OKAY
  always_comb begin
    hready_s = 1'b1;
    hresp_s  = HRESP_OKAY;
    hrdata_s = 32'h0000_0000;
    if (sel_q_r[SEL_P0]) begin
      hready_s = P0_HREADYOUT;
      hresp_s  = P0_HRESP;
      hrdata_s = P0_HRDATA;
    end else if (sel_q_r[SEL_P1]) begin
      hready_s = P1_HREADYOUT;
      hresp_s  = P1_HRESP;
      hrdata_s = P1_HRDATA;
    end else if (sel_q_r[SEL_P2]) begin
      hready_s = P2_HREADYOUT;
      hresp_s  = P2_HRESP;
      hrdata_s = P2_HRDATA;
    end else if (sel_q_r[SEL_P3]) begin
      hready_s = P3_HREADYOUT;
      hresp_s  = P3_HRESP;
      hrdata_s = P3_HRDATA;
    end else if (sel_q_r[SEL_DEF]) begin
      hready_s = ds_hreadyout_s;
      hresp_s  = ds_hresp_s;
      hrdata_s = 32'h0000_0000;
    end else if (sel_q_r[SEL_NONE]) begin
      hready_s = 1'b1;
      hresp_s  = HRESP_OKAY;
      hrdata_s = 32'h0000_0000;
    end else begin
      hready_s = 1'b1;
      hresp_s  = HRESP_OKAY;
      hrdata_s = 32'h0000_0000;
    end
  end

  assign HREADY = hready_s;
  assign HRESP  = hresp_s;
  assign HRDATA = hrdata_s;

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// Directed bench: dut_a has all four ports enabled, dut_b has port 3 absent;
// both share one master/slave stimulus and are checked against fixed values.
module tb_ahblite_slave_mux;
  import ahblite_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b0;
  logic [1:0]  HTRANS;
  logic        p0_hsel, p1_hsel, p2_hsel, p3_hsel;
  logic        p0_rdy, p1_rdy, p2_rdy, p3_rdy;
  logic        p0_resp, p1_resp, p2_resp, p3_resp;
  logic [31:0] p0_data, p1_data, p2_data, p3_data;
  logic        hready_a, hresp_a, hready_b, hresp_b;
  logic [31:0] hrdata_a, hrdata_b;
  logic [33:0] obs_a, obs_b, e, e2;
  int          n_cmp, n_bad;

  localparam logic [33:0] OK0 = {1'b1, 1'b0, 32'h0000_0000};

  always #5 HCLK = ~HCLK;

  assign obs_a = {hready_a, hresp_a, hrdata_a};
  assign obs_b = {hready_b, hresp_b, hrdata_b};

  ahblite_slave_mux #(.Port0_en(1'b1), .Port1_en(1'b1), .Port2_en(1'b1), .Port3_en(1'b1)) dut_a (
    .HCLK(HCLK), .HRESET(HRESET), .HTRANS(HTRANS),
    .P0_HSEL(p0_hsel), .P1_HSEL(p1_hsel), .P2_HSEL(p2_hsel), .P3_HSEL(p3_hsel),
    .P0_HREADYOUT(p0_rdy), .P1_HREADYOUT(p1_rdy), .P2_HREADYOUT(p2_rdy), .P3_HREADYOUT(p3_rdy),
    .P0_HRESP(p0_resp), .P1_HRESP(p1_resp), .P2_HRESP(p2_resp), .P3_HRESP(p3_resp),
    .P0_HRDATA(p0_data), .P1_HRDATA(p1_data), .P2_HRDATA(p2_data), .P3_HRDATA(p3_data),
    .HREADY(hready_a), .HRESP(hresp_a), .HRDATA(hrdata_a));

  ahblite_slave_mux #(.Port0_en(1'b1), .Port1_en(1'b1), .Port2_en(1'b1), .Port3_en(1'b0)) dut_b (
    .HCLK(HCLK), .HRESET(HRESET), .HTRANS(HTRANS),
    .P0_HSEL(p0_hsel), .P1_HSEL(p1_hsel), .P2_HSEL(p2_hsel), .P3_HSEL(p3_hsel),
    .P0_HREADYOUT(p0_rdy), .P1_HREADYOUT(p1_rdy), .P2_HREADYOUT(p2_rdy), .P3_HREADYOUT(p3_rdy),
    .P0_HRESP(p0_resp), .P1_HRESP(p1_resp), .P2_HRESP(p2_resp), .P3_HRESP(p3_resp),
    .P0_HRDATA(p0_data), .P1_HRDATA(p1_data), .P2_HRDATA(p2_data), .P3_HRDATA(p3_data),
    .HREADY(hready_b), .HRESP(hresp_b), .HRDATA(hrdata_b));

  // The decoder must never select more than one slave at once
  hsel_onehot: assert property (@(posedge HCLK) disable iff (HRESET)
    $onehot0({p3_hsel, p2_hsel, p1_hsel, p0_hsel}));

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_inputs();
    HTRANS = HTRANS_IDLE;
    {p0_hsel, p1_hsel, p2_hsel, p3_hsel} = 4'b0000;
    {p0_rdy, p1_rdy, p2_rdy, p3_rdy} = 4'b1111;
    {p0_resp, p1_resp, p2_resp, p3_resp} = 4'b0000;
    p0_data = 32'hA000_0000;
    p1_data = 32'hA111_1111;
    p2_data = 32'hA222_2222;
    p3_data = 32'hA333_3333;
  endtask

  task automatic test_reset();
    HTRANS = 2'($urandom_range(3));
    {p0_hsel, p1_hsel, p2_hsel, p3_hsel} = 4'($urandom_range(15));
    {p0_rdy, p1_rdy, p2_rdy, p3_rdy} = 4'($urandom_range(15));
    {p0_resp, p1_resp, p2_resp, p3_resp} = 4'($urandom_range(15));
    p0_data = $urandom; p1_data = $urandom; p2_data = $urandom; p3_data = $urandom;
    #1 HRESET = 1'b1;
    #1;
    n_cmp++; if ({obs_a, obs_b} !== {OK0, OK0}) begin n_bad++; $display("FAIL rst_async: got a=%h b=%h exp %h", obs_a, obs_b, OK0); end
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    n_cmp++; if ({obs_a, obs_b} !== {OK0, OK0}) begin n_bad++; $display("FAIL rst_held: got a=%h b=%h exp %h", obs_a, obs_b, OK0); end
    tick();
    HRESET = 1'b0;
    idle_inputs();
    @(negedge HCLK);
    n_cmp++; if ({obs_a, obs_b} !== {OK0, OK0}) begin n_bad++; $display("FAIL rst_release: got a=%h b=%h exp %h", obs_a, obs_b, OK0); end
    tick();
  endtask

  task automatic test_wait_state();
    idle_inputs();
    HTRANS = HTRANS_NONSEQ; p1_hsel = 1'b1;
    @(negedge HCLK);
    n_cmp++; if ({obs_a, obs_b} !== {OK0, OK0}) begin n_bad++; $display("FAIL ws_addr: got a=%h b=%h exp %h", obs_a, obs_b, OK0); end
    tick();
    HTRANS = HTRANS_IDLE; p1_hsel = 1'b0; p1_rdy = 1'b0; p1_data = 32'hCAFE_0001;
    @(negedge HCLK);
    e = {1'b0, 1'b0, 32'hCAFE_0001};
    n_cmp++; if ({obs_a, obs_b} !== {e, e}) begin n_bad++; $display("FAIL ws_wait1: got a=%h b=%h exp %h", obs_a, obs_b, e); end
    tick();
    @(negedge HCLK);
    n_cmp++; if ({obs_a, obs_b} !== {e, e}) begin n_bad++; $display("FAIL ws_wait2: got a=%h b=%h exp %h", obs_a, obs_b, e); end
    tick();
    p1_rdy = 1'b1;
    @(negedge HCLK);
    e = {1'b1, 1'b0, 32'hCAFE_0001};
    n_cmp++; if ({obs_a, obs_b} !== {e, e}) begin n_bad++; $display("FAIL ws_done: got a=%h b=%h exp %h", obs_a, obs_b, e); end
    tick();
    @(negedge HCLK);
    n_cmp++; if ({obs_a, obs_b} !== {OK0, OK0}) begin n_bad++; $display("FAIL ws_after: got a=%h b=%h exp %h", obs_a, obs_b, OK0); end
    tick();
  endtask

  task automatic test_default_err();
    idle_inputs();
    HTRANS = HTRANS_NONSEQ;
    @(negedge HCLK);
    n_cmp++; if ({obs_a, obs_b} !== {OK0, OK0}) begin n_bad++; $display("FAIL de_addr: got a=%h b=%h exp %h", obs_a, obs_b, OK0); end
    tick();
    @(negedge HCLK);
    e = {1'b0, 1'b1, 32'h0000_0000};
    n_cmp++; if ({obs_a, obs_b} !== {e, e}) begin n_bad++; $display("FAIL de_err1a: got a=%h b=%h exp %h", obs_a, obs_b, e); end
    tick();
    @(negedge HCLK);
    e = {1'b1, 1'b1, 32'h0000_0000};
    n_cmp++; if ({obs_a, obs_b} !== {e, e}) begin n_bad++; $display("FAIL de_err2a: got a=%h b=%h exp %h", obs_a, obs_b, e); end
    tick();
    HTRANS = HTRANS_IDLE;
    @(negedge HCLK);
    e = {1'b0, 1'b1, 32'h0000_0000};
    n_cmp++; if ({obs_a, obs_b} !== {e, e}) begin n_bad++; $display("FAIL de_err1b: got a=%h b=%h exp %h", obs_a, obs_b, e); end
    tick();
    @(negedge HCLK);
    e = {1'b1, 1'b1, 32'h0000_0000};
    n_cmp++; if ({obs_a, obs_b} !== {e, e}) begin n_bad++; $display("FAIL de_err2b: got a=%h b=%h exp %h", obs_a, obs_b, e); end
    tick();
    @(negedge HCLK);
    n_cmp++; if ({obs_a, obs_b} !== {OK0, OK0}) begin n_bad++; $display("FAIL de_after: got a=%h b=%h exp %h", obs_a, obs_b, OK0); end
    tick();
  endtask

  task automatic test_port3();
    idle_inputs();
    HTRANS = HTRANS_NONSEQ; p3_hsel = 1'b1; p3_data = 32'hFFFF_FFFF;
    @(negedge HCLK);
    n_cmp++; if ({obs_a, obs_b} !== {OK0, OK0}) begin n_bad++; $display("FAIL p3_addr: got a=%h b=%h exp %h", obs_a, obs_b, OK0); end
    tick();
    HTRANS = HTRANS_IDLE;
    @(negedge HCLK);
    e  = {1'b1, 1'b0, 32'hFFFF_FFFF};
    e2 = {1'b0, 1'b1, 32'h0000_0000};
    n_cmp++; if ({obs_a, obs_b} !== {e, e2}) begin n_bad++; $display("FAIL p3_data: got a=%h b=%h exp a=%h b=%h", obs_a, obs_b, e, e2); end
    tick();
    @(negedge HCLK);
    e2 = {1'b1, 1'b1, 32'h0000_0000};
    n_cmp++; if ({obs_a, obs_b} !== {e, e2}) begin n_bad++; $display("FAIL p3_err2: got a=%h b=%h exp a=%h b=%h", obs_a, obs_b, e, e2); end
    tick();
    @(negedge HCLK);
    n_cmp++; if ({obs_a, obs_b} !== {e, OK0}) begin n_bad++; $display("FAIL p3_idle_okay: got a=%h b=%h exp a=%h b=%h", obs_a, obs_b, e, OK0); end
    tick();
    p3_hsel = 1'b0;
    @(negedge HCLK);
    n_cmp++; if ({obs_a, obs_b} !== {e, OK0}) begin n_bad++; $display("FAIL p3_hold: got a=%h b=%h exp a=%h b=%h", obs_a, obs_b, e, OK0); end
    tick();
    @(negedge HCLK);
    n_cmp++; if ({obs_a, obs_b} !== {OK0, OK0}) begin n_bad++; $display("FAIL p3_clear: got a=%h b=%h exp %h", obs_a, obs_b, OK0); end
    tick();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    HTRANS = HTRANS_NONSEQ; p0_hsel = 1'b1;
    @(negedge HCLK);
    n_cmp++; if ({obs_a, obs_b} !== {OK0, OK0}) begin n_bad++; $display("FAIL b2b_first: got a=%h b=%h exp %h", obs_a, obs_b, OK0); end
    tick();
    p0_hsel = 1'b0; p2_hsel = 1'b1; p0_data = 32'h0000_0011; p2_resp = 1'b1;
    @(negedge HCLK);
    e = {1'b1, 1'b0, 32'h0000_0011};
    n_cmp++; if ({obs_a, obs_b} !== {e, e}) begin n_bad++; $display("FAIL b2b_p0: got a=%h b=%h exp %h", obs_a, obs_b, e); end
    tick();
    p2_hsel = 1'b0; p0_hsel = 1'b1; p2_data = 32'h0000_0022; p2_resp = 1'b0; p0_data = 32'h0000_00EE; p0_resp = 1'b1;
    @(negedge HCLK);
    e = {1'b1, 1'b0, 32'h0000_0022};
    n_cmp++; if ({obs_a, obs_b} !== {e, e}) begin n_bad++; $display("FAIL b2b_p2: got a=%h b=%h exp %h", obs_a, obs_b, e); end
    tick();
    HTRANS = HTRANS_IDLE; p0_hsel = 1'b0; p0_data = 32'h0000_0033; p0_resp = 1'b0; p2_data = 32'h0000_00DD;
    @(negedge HCLK);
    e = {1'b1, 1'b0, 32'h0000_0033};
    n_cmp++; if ({obs_a, obs_b} !== {e, e}) begin n_bad++; $display("FAIL b2b_p0_again: got a=%h b=%h exp %h", obs_a, obs_b, e); end
    tick();
    @(negedge HCLK);
    n_cmp++; if ({obs_a, obs_b} !== {OK0, OK0}) begin n_bad++; $display("FAIL b2b_after: got a=%h b=%h exp %h", obs_a, obs_b, OK0); end
    tick();
  endtask

  task automatic test_reset_mid_err();
    idle_inputs();
    HTRANS = HTRANS_NONSEQ;
    tick();
    HTRANS = HTRANS_IDLE;
    @(negedge HCLK);
    e = {1'b0, 1'b1, 32'h0000_0000};
    n_cmp++; if ({obs_a, obs_b} !== {e, e}) begin n_bad++; $display("FAIL rm_err1: got a=%h b=%h exp %h", obs_a, obs_b, e); end
    #1 HRESET = 1'b1;
    #1;
    n_cmp++; if ({obs_a, obs_b} !== {OK0, OK0}) begin n_bad++; $display("FAIL rm_async: got a=%h b=%h exp %h", obs_a, obs_b, OK0); end
    tick();
    HRESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      n_cmp++; if ({obs_a, obs_b} !== {OK0, OK0}) begin n_bad++; $display("FAIL rm_idle%0d: got a=%h b=%h exp %h", i, obs_a, obs_b, OK0); end
      tick();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_wait_state();
    test_default_err();
    test_port3();
    test_back_to_back();
    test_reset_mid_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
